// File: rtl/nn_pkg.sv
// Shared word type, FSM encoding and accumulator arithmetic for nn_layer_engine.
// Defining NN_SATURATE_EN makes acc_add saturate; otherwise it wraps.
package nn_pkg;
    localparam int NN_INT_W  = 8;
    localparam int NN_FRAC_W = 8;
    localparam int NN_NUM_W  = NN_INT_W + NN_FRAC_W;

    typedef logic signed [NN_NUM_W-1:0] num_t;
    typedef enum logic [2:0] {IDLE, WAIT_F, WAIT_B, RUN_F, RUN_B} state_e;

    function automatic num_t wrap_add(num_t a, num_t b);
        return a + b;
    endfunction

    // Overflow only when both operands share a sign that the sum lost.
    function automatic num_t sat_add(num_t a, num_t b);
        num_t s;
        s = a + b;
        if (a[NN_NUM_W-1] == b[NN_NUM_W-1] && s[NN_NUM_W-1] != a[NN_NUM_W-1])
            s = a[NN_NUM_W-1] ? {1'b1, {(NN_NUM_W-1){1'b0}}} : {1'b0, {(NN_NUM_W-1){1'b1}}};
        return s;
    endfunction

    function automatic num_t acc_add(num_t a, num_t b);
`ifdef NN_SATURATE_EN
        return sat_add(a, b);
`else
        return wrap_add(a, b);
`endif
    endfunction

    function automatic num_t leaky_relu(num_t v, int unsigned shift);
        return (v > 0) ? v : (v >>> shift);
    endfunction
endpackage

// File: rtl/nn_layer_engine_if.sv
// Handshake, weight-RAM and shared-multiplier bus of nn_layer_engine.
// master = engine side, slave = RAM/multiplier/neighbouring-layer side.
interface nn_layer_engine_if #(
    parameter int NUM_W      = 16,
    parameter int RAM_ADDR_W = 8
);
    logic                  start_f, start_b, ready_f_in, ready_b_in;
    logic                  ready_out, done;
    logic                  mult_en;
    logic [NUM_W-1:0]      mult_v1, mult_v2, mult_res;
    logic                  ram_rd;
    logic [RAM_ADDR_W-1:0] ram_addr_read;
    logic [NUM_W-1:0]      ram_data_read;

    modport master (
        input  start_f, start_b, ready_f_in, ready_b_in, mult_res, ram_data_read,
        output ready_out, done, mult_en, mult_v1, mult_v2, ram_rd, ram_addr_read
    );
    modport slave (
        output start_f, start_b, ready_f_in, ready_b_in, mult_res, ram_data_read,
        input  ready_out, done, mult_en, mult_v1, mult_v2, ram_rd, ram_addr_read
    );
endinterface

// File: rtl/nn_rd_tag_pipe.sv
// Carries the {valid, neuron, word} tag of each RAM read alongside the RAM latency,
// so the tag leaves the pipe in the same cycle its data word arrives.
module nn_rd_tag_pipe #(
    parameter int DEPTH = 3,
    parameter int N_W   = 1,
    parameter int W_W   = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           in_valid,
    input  logic [N_W-1:0] in_n,
    input  logic [W_W-1:0] in_w,
    output logic           out_valid,
    output logic [N_W-1:0] out_n,
    output logic [W_W-1:0] out_w
);
    typedef struct packed {
        logic           valid;
        logic [N_W-1:0] n;
        logic [W_W-1:0] w;
    } tag_t;

    tag_t pipe [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (enable) begin
            pipe[0] <= {in_valid, in_n, in_w};
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {out_valid, out_n, out_w} = pipe[DEPTH-1];
endmodule

// File: rtl/nn_layer_engine.sv
// Fully-connected leaky-ReLU layer, forward and backward passes, over one external multiplier.
// Define NN_SATURATE_EN for saturating accumulation; otherwise accumulator adds wrap.
module nn_layer_engine
    import nn_pkg::*;
#(
    parameter int INT_W          = NN_INT_W,
    parameter int FRAC_W         = NN_FRAC_W,
    parameter int INPUTS         = 4,
    parameter int OUTPUTS        = 4,
    parameter int RAM_ADDR_W     = 8,
    parameter int RAM_ADDR_START = 0,
    parameter int RAM_DELAY      = 3,
    parameter int RELU_SHIFT     = 4,
    localparam int NUM_W         = INT_W + FRAC_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [INPUTS-1:0][NUM_W-1:0]    inputs_f,
    input  logic [OUTPUTS-1:0][NUM_W-1:0]   inputs_b,
    output logic [OUTPUTS-1:0][NUM_W-1:0]   output_f,
    output logic [INPUTS-1:0][NUM_W-1:0]    output_b,
    nn_layer_engine_if.master               bus
);
    localparam int READS   = OUTPUTS * (INPUTS + 1);
    localparam int RUN_LEN = READS + RAM_DELAY;
    localparam int CNT_W   = $clog2(RUN_LEN + 1);
    localparam int N_W     = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
    localparam int W_W     = $clog2(INPUTS + 1);

    state_e           state;
    num_t             results_f [OUTPUTS];
    num_t             results_b [INPUTS];
    logic [N_W-1:0]   n_iss, tn;
    logic [W_W-1:0]   w_iss, tw;
    logic [CNT_W-1:0] cnt;
    logic             tv, running, is_bias;
    num_t             x_sel, rf_sel, gb, g;

    nn_rd_tag_pipe #(.DEPTH(RAM_DELAY), .N_W(N_W), .W_W(W_W)) u_tag_pipe (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(bus.ram_rd), .in_n(n_iss), .in_w(w_iss),
        .out_valid(tv), .out_n(tn), .out_w(tw)
    );

    assign running = (state == RUN_F) || (state == RUN_B);
    assign is_bias = (tw == W_W'(INPUTS));

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < INPUTS; i++) if (tw == W_W'(i)) x_sel = inputs_f[i];
    end

    always_comb begin
        rf_sel = '0;
        gb     = '0;
        for (int i = 0; i < OUTPUTS; i++)
            if (tn == N_W'(i)) begin
                rf_sel = results_f[i];
                gb     = inputs_b[i];
            end
    end

    // Upstream gradient through the leaky-ReLU derivative of the stored pre-activation.
    assign g = (rf_sel > 0) ? gb : (gb >>> RELU_SHIFT);

    assign bus.mult_en = running && enable && tv && !is_bias;
    assign bus.mult_v1 = bus.mult_en ? bus.ram_data_read : '0;
    assign bus.mult_v2 = bus.mult_en ? ((state == RUN_F) ? x_sel : g) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            n_iss             <= '0;
            w_iss             <= '0;
            cnt               <= '0;
            bus.ram_rd        <= 1'b0;
            bus.ram_addr_read <= '0;
            bus.done          <= 1'b0;
            bus.ready_out     <= 1'b1;
            for (int i = 0; i < OUTPUTS; i++) results_f[i] <= '0;
            for (int i = 0; i < INPUTS; i++)  results_b[i] <= '0;
        end else if (enable) begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_f) begin
                        state         <= WAIT_F;
                        bus.ready_out <= 1'b0;
                        for (int i = 0; i < OUTPUTS; i++) results_f[i] <= '0;
                    end else if (bus.start_b) begin
                        state         <= WAIT_B;
                        bus.ready_out <= 1'b0;
                        for (int i = 0; i < INPUTS; i++) results_b[i] <= '0;
                    end
                end
                WAIT_F, WAIT_B: begin
                    if ((state == WAIT_F) ? bus.ready_f_in : bus.ready_b_in) begin
                        state             <= (state == WAIT_F) ? RUN_F : RUN_B;
                        bus.ram_rd        <= 1'b1;
                        bus.ram_addr_read <= RAM_ADDR_W'(RAM_ADDR_START);
                        n_iss             <= '0;
                        w_iss             <= '0;
                        cnt               <= '0;
                    end
                end
                RUN_F, RUN_B: begin
                    if (bus.ram_rd) begin
                        if (w_iss == W_W'(INPUTS)) begin
                            w_iss <= '0;
                            n_iss <= n_iss + 1'b1;
                            if (n_iss == N_W'(OUTPUTS - 1)) bus.ram_rd <= 1'b0;
                            else bus.ram_addr_read <= bus.ram_addr_read + 1'b1;
                        end else begin
                            w_iss             <= w_iss + 1'b1;
                            bus.ram_addr_read <= bus.ram_addr_read + 1'b1;
                        end
                    end
                    // Fixed run length: done lands in the cycle the last tag is consumed.
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(RUN_LEN - 2)) bus.done <= 1'b1;
                    if (cnt == CNT_W'(RUN_LEN - 1)) begin
                        state         <= IDLE;
                        bus.ready_out <= 1'b1;
                    end
                    if (tv && state == RUN_F) begin
                        for (int i = 0; i < OUTPUTS; i++)
                            if (tn == N_W'(i))
                                results_f[i] <= acc_add(results_f[i],
                                    is_bias ? num_t'(bus.ram_data_read) : num_t'(bus.mult_res));
                    end
                    if (tv && state == RUN_B && !is_bias) begin
                        for (int i = 0; i < INPUTS; i++)
                            if (tw == W_W'(i))
                                results_b[i] <= acc_add(results_b[i], num_t'(bus.mult_res));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < OUTPUTS; i++) begin : g_out_f
        assign output_f[i] = leaky_relu(results_f[i], RELU_SHIFT);
    end
    for (genvar i = 0; i < INPUTS; i++) begin : g_out_b
        assign output_b[i] = results_b[i];
    end
endmodule
